// File: rtl/prbs31_checker_if.sv
// Receive-side bundle between the PRBS31 checker and its host: bit stream in, lock/error status out.
// bit_count exists only when PRBS31_CHK_BITCNT_EN is defined.
interface prbs31_checker_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 din_valid;
  logic                 din;
  logic                 clr_cnt;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
`ifdef PRBS31_CHK_BITCNT_EN
  logic [31:0]          bit_count;

  modport master (output din_valid, din, clr_cnt,
                  input  locked, err_pulse, err_count, bit_count);
  modport slave  (input  din_valid, din, clr_cnt,
                  output locked, err_pulse, err_count, bit_count);
`else
  modport master (output din_valid, din, clr_cnt,
                  input  locked, err_pulse, err_count);
  modport slave  (input  din_valid, din, clr_cnt,
                  output locked, err_pulse, err_count);
`endif
endinterface

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 (x^31 + x^28 + 1) checker: seed, verify, then count bit errors while locked.
// Optional locked-bit counter is enabled by PRBS31_CHK_BITCNT_EN; err_pulse and locked are registered (latency 1).
module prbs31_checker #(
  parameter int ERR_CNT_W   = 16,
  parameter int LOCK_BITS   = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int UNLOCK_WIN  = 256
) (
  input  logic            clk,
  input  logic            rst,
  prbs31_checker_if.slave bus
);

  localparam int MATCH_W = $clog2(LOCK_BITS + 1);
  localparam int WIN_W   = $clog2(UNLOCK_WIN);
  localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_BITS - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(UNLOCK_WIN - 1);
  localparam logic [WERR_W-1:0]  WERR_LIM   = WERR_W'(UNLOCK_ERRS);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [30:0]          lfsr_q, lfsr_d;
  logic [4:0]           seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]    win_err_q, win_err_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 locked_q, locked_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic        pred;
  logic        err_hit;
  logic [30:0] lfsr_seed;
  logic [30:0] lfsr_run;

  assign pred      = lfsr_q[30] ^ lfsr_q[27];
  assign lfsr_seed = {lfsr_q[29:0], bus.din};
  assign lfsr_run  = {lfsr_q[29:0], pred};

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_hit     = 1'b0;

    if (bus.din_valid) begin
      case (state_q)
        SEED: begin
          lfsr_d = lfsr_seed;
          if (seed_cnt_q == 5'd30) begin
            seed_cnt_d = '0;
            // An all-zero seed would happily lock onto a dead (constant-0) line.
            if (lfsr_seed != '0) state_d = VERIFY;
          end else begin
            seed_cnt_d = seed_cnt_q + 5'd1;
          end
        end
        VERIFY: begin
          lfsr_d = lfsr_run;
          if (bus.din == pred) begin
            if (match_cnt_q == MATCH_LAST) begin
              match_cnt_d = '0;
              state_d     = LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            state_d     = SEED;
            match_cnt_d = '0;
            seed_cnt_d  = '0;
          end
        end
        LOCKED: begin
          lfsr_d      = lfsr_run;
          err_hit     = bus.din ^ pred;
          err_pulse_d = err_hit;
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = WERR_W'(err_hit);
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + WERR_W'(err_hit);
          end
          if (win_err_d == WERR_LIM) begin
            state_d     = SEED;
            win_cnt_d   = '0;
            win_err_d   = '0;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end

    // A coincident clear wins; that error still pulses but is not counted.
    err_count_d = err_count_q;
    if (bus.clr_cnt)                      err_count_d = '0;
    else if (err_hit && err_count_q != '1) err_count_d = err_count_q + 1'b1;

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEED;
      lfsr_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

`ifdef PRBS31_CHK_BITCNT_EN
  logic [31:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (bus.clr_cnt)
      bit_count_d = '0;
    else if (bus.din_valid && state_q == LOCKED && bit_count_q != '1)
      bit_count_d = bit_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bit_count_q <= '0;
    else     bit_count_q <= bit_count_d;
  end

  assign bus.bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: stimulus queues expected pulse/lock events, a monitor pops and compares them.
// A second instance with a 4-bit error counter shares the stimulus to exercise saturation.
module tb_prbs31_checker;

  localparam int EV_PULSE = 0;
  localparam int EV_RISE  = 1;
  localparam int EV_FALL  = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic din_valid;
  logic din;
  logic clr_cnt;

  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic prev_locked = 1'b0;
  logic [30:0] g;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prbs31_checker_if #(.ERR_CNT_W(16)) bus_w ();
  prbs31_checker_if #(.ERR_CNT_W(4))  bus_n ();

  assign bus_w.din_valid = din_valid;
  assign bus_w.din       = din;
  assign bus_w.clr_cnt   = clr_cnt;
  assign bus_n.din_valid = din_valid;
  assign bus_n.din       = din;
  assign bus_n.clr_cnt   = clr_cnt;

  prbs31_checker #(.ERR_CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus_w));
  prbs31_checker #(.ERR_CNT_W(4))  u_dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    chk_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL event: unexpected kind %0d at cycle %0d, none expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.cyc == cyc) pass_cnt++;
      else $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                    kind, cyc, e.kind, e.cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  function automatic logic gen_bit();
    logic o;
    o = g[30] ^ g[27];
    g = {g[29:0], o};
    return o;
  endfunction

  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge clk);
    #1;
    din_valid = v;
    din       = b;
    clr_cnt   = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic send_prbs(input int n, input int lock_at);
    for (int i = 1; i <= n; i++) begin
      drive(1'b1, gen_bit(), 1'b0);
      if (i == lock_at) push_ev(EV_RISE, cyc + 1);
    end
  endtask

  task automatic send_err(input logic clr, input logic falls);
    drive(1'b1, ~gen_bit(), clr);
    push_ev(EV_PULSE, cyc + 1);
    if (falls) push_ev(EV_FALL, cyc + 1);
  endtask

  task automatic pulse_rst(input logic was_locked);
    @(negedge clk);
    #1;
    rst = 1'b1;
    din_valid = 1'b0;
    if (was_locked) push_ev(EV_FALL, cyc + 1);
    @(negedge clk);
    #1;
    check("rst_locked", bus_w.locked, 0);
    check("rst_err_count", bus_w.err_count, 0);
    rst = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus_w.err_pulse === 1'b1) check_event(EV_PULSE);
      if (bus_w.locked !== prev_locked) check_event(bus_w.locked === 1'b1 ? EV_RISE : EV_FALL);
      prev_locked = bus_w.locked;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    din_valid = 1'b0;
    din = 1'b0;
    clr_cnt = 1'b0;
    g = 31'h1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_locked", bus_w.locked, 0);
    check("reset_err_pulse", bus_w.err_pulse, 0);
    check("reset_err_count", bus_w.err_count, 0);
    check("reset_err_count_n", bus_n.err_count, 0);
    rst = 1'b0;

    // Idle: nothing may happen while din_valid stays low.
    repeat (100) idle();
    check("idle_locked", bus_w.locked, 0);
    check("idle_err_count", bus_w.err_count, 0);

    // Clean lock: 31 seed + 64 verify bits, then a long clean run.
    g = 31'h1;
    send_prbs(95, 95);
    send_prbs(10000, 0);
    idle();
    check("clean_locked", bus_w.locked, 1);
    check("clean_err_count", bus_w.err_count, 0);
`ifdef PRBS31_CHK_BITCNT_EN
    check("clean_bit_count", bus_w.bit_count, 10000);
`endif

    // Single error: one pulse, count 1, stay locked.
    send_err(1'b0, 1'b0);
    send_prbs(300, 0);
    idle();
    check("single_err_count", bus_w.err_count, 1);
    check("single_locked", bus_w.locked, 1);

    // Loss of lock: 8 errors inside one window, then relock on the clean stream.
    drive(1'b0, 1'b0, 1'b1);
    idle();
    check("clr_err_count", bus_w.err_count, 0);
    for (int k = 1; k <= 8; k++) begin
      send_err(1'b0, k == 8);
      if (k < 8) send_prbs(9, 0);
    end
    idle();
    check("unlock_locked", bus_w.locked, 0);
    send_prbs(95, 95);
    idle();
    check("unlock_err_count", bus_w.err_count, 8);
    check("relock_locked", bus_w.locked, 1);

    // Reset mid-operation, all-zero seed, then an error on the 40th verify bit.
    pulse_rst(1'b1);
    repeat (31) drive(1'b1, 1'b0, 1'b0);
    g = 31'h1;
    send_prbs(31 + 39, 0);
    drive(1'b1, ~gen_bit(), 1'b0);
    send_prbs(95, 95);
    idle();
    check("verify_err_count", bus_w.err_count, 0);
    check("verify_relock", bus_w.locked, 1);

    // Gapped valid: lock point counted in valid bits only.
    pulse_rst(1'b1);
    g = 31'h1;
    for (int i = 1; i <= 95; i++) begin
      drive(1'b1, gen_bit(), 1'b0);
      if (i == 95) push_ev(EV_RISE, cyc + 1);
      idle();
    end
    check("gapped_locked", bus_w.locked, 1);

    // Clear coincident with an error: pulses, but the count ends at zero.
    send_err(1'b0, 1'b0);
    send_prbs(50, 0);
    idle();
    check("pre_clr_err_count", bus_w.err_count, 1);
    send_err(1'b1, 1'b0);
    idle();
    check("clr_coincident_err_count", bus_w.err_count, 0);

    // Saturation: 20 errors at 4 per window; 4-bit counter holds at 15.
    for (int k = 0; k < 20; k++) begin
      send_err(1'b0, 1'b0);
      send_prbs(63, 0);
    end
    idle();
    check("sat_err_count_w", bus_w.err_count, 20);
    check("sat_err_count_n", bus_n.err_count, 15);
    check("sat_locked_n", bus_n.locked, 1);
    check("sat_locked_w", bus_w.locked, 1);

    repeat (5) idle();
    check("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side companion to the PRBS31 generator (polynomial x^31 + x^28 + 1).
- Consumes a serial bit stream with a valid qualifier and self-synchronises by seeding a local LFSR from the incoming bits.
- After seeding, it verifies lock, then counts bit errors against the locally predicted sequence.
- Used on the loopback/receive path to measure link bit-error rate.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.
- LOCK_BITS, 64, consecutive matching bits in VERIFY required to declare lock.
- UNLOCK_ERRS, 8, errors within one window that force loss of lock.
- UNLOCK_WIN, 256, window length in valid bits for the unlock error budget.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  din carries a bit this cycle.
- din  in  1  received serial bit.
- clr_cnt  in  1  synchronous clear of err_count (and bit_count when present).
- locked  out  1  high while FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_count  out  ERR_CNT_W  saturating count of errors seen while LOCKED.

Behaviour:
- Reset (async, rst=1): FSM=SEED, lfsr=0, seed/lock/window counters=0, locked=0, err_pulse=0, err_count=0.
- LFSR s[30:0]; predicted bit p = s[30] ^ s[27]. Cycles with din_valid=0 change no state; err_pulse is 0 on those cycles.
- SEED state:
  - Each valid bit: s <= {s[29:0], din}; seed counter increments.
  - After the 31st valid bit, if the seeded s is nonzero, go to VERIFY. If it is all-zero, restart SEED (counter=0), because a zero state would lock onto a constant-0 stream.
- VERIFY state:
  - Each valid bit: s <= {s[29:0], p}. The checker free-runs and never shifts din in, so errors do not propagate.
  - din==p increments the match counter; LOCK_BITS matches go to LOCKED.
  - Any mismatch returns to SEED with all counters zeroed. No err_pulse and no err_count change in VERIFY.
- LOCKED state:
  - Each valid bit: s <= {s[29:0], p}; err = din ^ p.
  - err=1: err_pulse=1 on the next cycle (registered, latency 1); err_count += 1, saturating at all-ones; window error counter += 1.
  - Window counter counts valid bits 0..UNLOCK_WIN-1. On wrap, the window error count resets to 0; if the wrapping bit is itself an error, the new window's count is 1.
  - When the window error count reaches UNLOCK_ERRS, go to SEED; locked drops on the next cycle. That final error still pulses and counts.
- locked is registered and equals (state==LOCKED), so it rises the cycle after the LOCK_BITS-th match.
- clr_cnt: err_count <= 0 on the next edge. It has priority over a simultaneous increment (the coincident error is dropped from the count but still pulses). It does not affect the FSM or the window counters.
- Reset mid-operation: immediate return to reset values, regardless of state.
- err_count is not cleared on loss of lock; it accumulates across relocks until clr_cnt or rst.

Optional Feature:
- Macro PRBS31_CHK_BITCNT_EN.
- Defined: adds output port bit_count [31:0]. It counts valid bits received while LOCKED, saturates at 32'hFFFFFFFF, is cleared by clr_cnt (same priority as err_count), and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse, din_valid=0 for 100 cycles -> locked=0, err_count=0, err_pulse never 1.
- Clean lock: stream from a reference PRBS31 seeded 31'h1, continuous valid -> locked rises exactly after 31+64=95 valid bits; 10000 further bits give err_count=0 (bit_count=10000 with BITCNT_EN).
- Single error injection: after lock, flip one bit -> err_pulse high for exactly one cycle, one cycle after that bit; err_count=1; locked stays 1; subsequent bits match.
- Loss of lock: after lock, flip 8 bits within 256 valid bits -> locked falls the cycle after the 8th error; err_count=8. The stream then continues cleanly -> relock after another 95 bits.
- All-zero and error-in-VERIFY: feed 31 zeros -> stays in SEED. Then seed correctly and flip bit 40 of VERIFY -> returns to SEED, locked never asserted, err_count=0.
- Gapped valid, clr_cnt and saturation: (a) din_valid toggling 1/0 -> same lock point in valid bits as the clean-lock case. (b) After lock, clr_cnt coincident with an error -> err_count=0, err_pulse=1. (c) ERR_CNT_W=4 with repeated errors paced to stay under UNLOCK_ERRS per window -> err_count holds at 15.
